// File: rtl/llc_pkg.sv
// llc_pkg: command encodings, arbiter FSM state type and command-class helpers
// shared by the LLC request arbiter and its round-robin picker.
package llc_pkg;

  localparam int CMD_BITS = 4;

  localparam logic [CMD_BITS-1:0] CMD_READ_D     = 4'd0;
  localparam logic [CMD_BITS-1:0] CMD_WRITE_D    = 4'd1;
  localparam logic [CMD_BITS-1:0] CMD_READ_I     = 4'd2;
  localparam logic [CMD_BITS-1:0] CMD_SNOOP_INV  = 4'd3;
  localparam logic [CMD_BITS-1:0] CMD_SNOOP_RD   = 4'd4;
  localparam logic [CMD_BITS-1:0] CMD_SNOOP_WR   = 4'd5;
  localparam logic [CMD_BITS-1:0] CMD_SNOOP_RWIM = 4'd6;
  localparam logic [CMD_BITS-1:0] CMD_CLEAR      = 4'd8;
  localparam logic [CMD_BITS-1:0] CMD_PRINT      = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } llc_state_e;

  // Data-side and instruction-side reads.
  function automatic logic is_read(input logic [CMD_BITS-1:0] cmd);
    return (cmd == CMD_READ_D) || (cmd == CMD_READ_I);
  endfunction

  function automatic logic is_write(input logic [CMD_BITS-1:0] cmd);
    return (cmd == CMD_WRITE_D);
  endfunction

  // Only reads and writes contribute to hit/miss statistics.
  function automatic logic is_counted(input logic [CMD_BITS-1:0] cmd);
    return is_read(cmd) || is_write(cmd);
  endfunction

endpackage

// File: rtl/llc_rr_pick.sv
// llc_rr_pick: combinational round-robin picker. Searches from last_grant+1
// (wrapping) and selects the first asserted request.
module llc_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o
);

  // Rotating priority search; the first hit after last_grant wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_i) + k) % NUM_REQ;
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDX_W'(idx);
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/llc_req_arbiter.sv
// llc_req_arbiter: shares the single LLC command port among NUM_REQ trace
// requesters, one operation in flight, response routed back to the owner.
// Optional statistics counters are compiled in with LLC_ARB_STATS_EN.
module llc_req_arbiter
  import llc_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CMD_W   = 4,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*CMD_W-1:0]    req_cmd,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        llc_valid,
  output logic [CMD_W-1:0]            llc_cmd,
  output logic [ADDR_W-1:0]           llc_addr,
  output logic [$clog2(NUM_REQ)-1:0]  llc_id,
  input  logic                        llc_done,
  input  logic                        llc_hit,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic                        rsp_hit,
  output logic                        busy
`ifdef LLC_ARB_STATS_EN
  ,
  input  logic                        stat_clr,
  output logic [CNT_W-1:0]            stat_reads,
  output logic [CNT_W-1:0]            stat_writes,
  output logic [CNT_W-1:0]            stat_hits,
  output logic [CNT_W-1:0]            stat_misses
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  llc_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    llc_id_q, llc_id_d;
  logic [CMD_W-1:0]    llc_cmd_q, llc_cmd_d;
  logic [ADDR_W-1:0]   llc_addr_q, llc_addr_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [NUM_REQ-1:0]  pick_grant_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_any_s;
  logic [NUM_REQ-1:0]  owner_onehot_s;

  llc_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant_s),
    .grant_idx_o  (pick_idx_s),
    .any_o        (pick_any_s)
  );

  // Next-state, grant capture and combinational accept for the sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    llc_id_d     = llc_id_q;
    llc_cmd_d    = llc_cmd_q;
    llc_addr_d   = llc_addr_q;
    rsp_hit_d    = rsp_hit_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          req_ready    = pick_grant_s;
          state_d      = WAIT;
          last_grant_d = pick_idx_s;
          llc_id_d     = pick_idx_s;
          llc_cmd_d    = req_cmd[pick_idx_s*CMD_W +: CMD_W];
          llc_addr_d   = req_addr[pick_idx_s*ADDR_W +: ADDR_W];
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (llc_done) begin
          state_d   = RESP;
          rsp_hit_d = llc_hit;
        end else begin
          state_d = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-operation registers; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      llc_id_q     <= '0;
      llc_cmd_q    <= '0;
      llc_addr_q   <= '0;
      rsp_hit_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      llc_id_q     <= llc_id_d;
      llc_cmd_q    <= llc_cmd_d;
      llc_addr_q   <= llc_addr_d;
      rsp_hit_q    <= rsp_hit_d;
    end
  end

  assign owner_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << llc_id_q;

  assign llc_valid = (state_q == WAIT);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP) ? owner_onehot_s : {NUM_REQ{1'b0}};
  assign rsp_hit   = rsp_hit_q;
  assign llc_cmd   = llc_cmd_q;
  assign llc_addr  = llc_addr_q;
  assign llc_id    = llc_id_q;

`ifdef LLC_ARB_STATS_EN
  logic [CNT_W-1:0] reads_q, writes_q, hits_q, misses_q;
  logic [CMD_BITS-1:0] cls_cmd_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign cls_cmd_s = CMD_BITS'(llc_cmd_q);

  // Saturating statistics, bumped once per completed operation in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reads_q  <= '0;
      writes_q <= '0;
      hits_q   <= '0;
      misses_q <= '0;
    end else if (stat_clr) begin
      reads_q  <= '0;
      writes_q <= '0;
      hits_q   <= '0;
      misses_q <= '0;
    end else if (state_q == RESP) begin
      if (is_read(cls_cmd_s))  reads_q  <= sat_inc(reads_q);
      if (is_write(cls_cmd_s)) writes_q <= sat_inc(writes_q);
      if (is_counted(cls_cmd_s) && rsp_hit_q)  hits_q   <= sat_inc(hits_q);
      if (is_counted(cls_cmd_s) && !rsp_hit_q) misses_q <= sat_inc(misses_q);
    end
  end

  assign stat_reads  = reads_q;
  assign stat_writes = writes_q;
  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_llc_req_arbiter.sv
// tb_llc_req_arbiter: directed and randomized checks of the LLC request
// arbiter against a timestamp-based transaction model.
module tb_llc_req_arbiter;

  localparam int NUM_REQ = 3;
  localparam int CMD_W   = 4;
  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = $clog2(NUM_REQ);

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ*CMD_W-1:0]   req_cmd = '0;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       llc_valid;
  logic [CMD_W-1:0]           llc_cmd;
  logic [ADDR_W-1:0]          llc_addr;
  logic [IDX_W-1:0]           llc_id;
  logic                       llc_done = 1'b0;
  logic                       llc_hit = 1'b0;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic                       rsp_hit;
  logic                       busy;
`ifdef LLC_ARB_STATS_EN
  logic                       stat_clr = 1'b0;
  logic [CNT_W-1:0]           stat_reads, stat_writes, stat_hits, stat_misses;
`endif

  llc_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .CMD_W   (CMD_W),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .llc_valid (llc_valid),
    .llc_cmd   (llc_cmd),
    .llc_addr  (llc_addr),
    .llc_id    (llc_id),
    .llc_done  (llc_done),
    .llc_hit   (llc_hit),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .busy      (busy)
`ifdef LLC_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // stimulus
  logic [NUM_REQ-1:0] s_valid = '0;
  logic [CMD_W-1:0]   s_cmd  [NUM_REQ];
  logic [ADDR_W-1:0]  s_addr [NUM_REQ];
  logic               s_done = 1'b0;
  logic               s_hit  = 1'b0;
  logic               s_clr  = 1'b0;
  int                 last_win = -1;

  // transaction model: one op with accept and done timestamps
  bit                 m_op;
  int                 m_acc, m_done, m_owner, m_last;
  logic [CMD_W-1:0]   m_cmd;
  logic [ADDR_W-1:0]  m_addr;
  logic               m_hit;
  int                 m_reads, m_writes, m_hits, m_misses;
  int                 acc_id_q[$];
  int                 acc_cyc_q[$];

  // last observed DUT values (for literal checks)
  logic [NUM_REQ-1:0] o_rsp;
  logic               o_lv, o_busy, o_hit;

  int cmd_pool[9] = '{0, 1, 2, 3, 4, 5, 6, 8, 9};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_op = 1'b0; m_acc = 0; m_done = -1; m_owner = 0; m_last = NUM_REQ - 1;
    m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0;
    last_win = -1;
  endtask

  task automatic do_reset();
    s_valid = '0; s_done = 1'b0; s_hit = 1'b0; s_clr = 1'b0;
    req_valid = '0; llc_done = 1'b0; llc_hit = 1'b0;
`ifdef LLC_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_llc_valid", llc_valid, 0);
    chk("rst_llc_cmd", llc_cmd, 0);
    chk("rst_llc_addr", llc_addr, 0);
    chk("rst_llc_id", llc_id, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_busy", busy, 0);
`ifdef LLC_ARB_STATS_EN
    chk("rst_stat_hits", stat_hits, 0);
    chk("rst_stat_reads", stat_reads, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: apply stimulus, compare DUT against the model, advance model.
  task automatic step();
    logic [NUM_REQ-1:0] e_ready, e_rsp;
    bit e_lv, e_busy;
    int win, j;
    @(negedge clk);
    req_valid = s_valid;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_cmd[i*CMD_W +: CMD_W]    = s_cmd[i];
      req_addr[i*ADDR_W +: ADDR_W] = s_addr[i];
    end
    llc_done = s_done;
    llc_hit  = s_hit;
`ifdef LLC_ARB_STATS_EN
    stat_clr = s_clr;
`endif
    #1;
    if (m_op && m_done >= 0 && cyc >= m_done + 2) m_op = 1'b0;
    win = -1;
    if (!m_op) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        j = (m_last + k) % NUM_REQ;
        if (win < 0 && s_valid[j]) win = j;
      end
    end
    e_ready = '0;
    if (win >= 0) e_ready[win] = 1'b1;
    e_lv   = m_op && cyc > m_acc && (m_done < 0 || cyc <= m_done);
    e_busy = m_op && cyc > m_acc && (m_done < 0 || cyc <= m_done + 1);
    e_rsp  = '0;
    if (m_op && m_done >= 0 && cyc == m_done + 1) e_rsp[m_owner] = 1'b1;

    o_rsp = rsp_valid; o_lv = llc_valid; o_busy = busy; o_hit = rsp_hit;
    chk("req_ready", req_ready, e_ready);
    chk("llc_valid", llc_valid, e_lv);
    chk("busy", busy, e_busy);
    chk("rsp_valid", rsp_valid, e_rsp);
    if (e_lv) begin
      chk("llc_cmd", llc_cmd, m_cmd);
      chk("llc_addr", llc_addr, m_addr);
      chk("llc_id", llc_id, m_owner);
    end
    if (e_rsp != 0) chk("rsp_hit", rsp_hit, m_hit);
`ifdef LLC_ARB_STATS_EN
    chk("stat_reads", stat_reads, m_reads);
    chk("stat_writes", stat_writes, m_writes);
    chk("stat_hits", stat_hits, m_hits);
    chk("stat_misses", stat_misses, m_misses);
`endif
    if (s_clr) begin
      m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0;
    end else if (e_rsp != 0) begin
      if (m_cmd == 0 || m_cmd == 2) m_reads = sat(m_reads);
      if (m_cmd == 1) m_writes = sat(m_writes);
      if (m_cmd <= 2 && m_hit) m_hits = sat(m_hits);
      if (m_cmd <= 2 && !m_hit) m_misses = sat(m_misses);
    end

    if (win >= 0) begin
      m_op = 1'b1; m_acc = cyc; m_done = -1; m_owner = win;
      m_cmd = s_cmd[win]; m_addr = s_addr[win]; m_last = win;
      acc_id_q.push_back(win);
      acc_cyc_q.push_back(cyc);
    end else if (e_lv && s_done && m_done < 0) begin
      m_done = cyc; m_hit = s_hit;
    end
    last_win = win;
    @(posedge clk);
    cyc++;
  endtask

  // Single op from requester 0: accept, done one cycle later, response.
  task automatic run_op(input logic [CMD_W-1:0] cmd, input logic hit, input logic clr_in_resp);
    s_valid = 3'b001; s_cmd[0] = cmd; s_addr[0] = 32'h0000_2000 + 32'(cmd);
    step();
    s_valid = '0; s_done = 1'b1; s_hit = hit;
    step();
    s_done = 1'b0; s_clr = clr_in_resp;
    step();
    s_clr = 1'b0;
    step();
  endtask

  initial begin
    int t0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_cmd[i] = '0; s_addr[i] = '0;
    end
    model_reset();

    // Test 1: single read from requester 0, done at T+3 with hit.
    do_reset();
    acc_cyc_q.delete(); acc_id_q.delete();
    s_valid = 3'b001; s_cmd[0] = 4'd0; s_addr[0] = 32'h0000_1000;
    step();
    s_valid = '0;
    step(); chk("t1_lv_T1", o_lv, 1'b1);
    step(); chk("t1_lv_T2", o_lv, 1'b1);
    s_done = 1'b1; s_hit = 1'b1;
    step(); chk("t1_lv_T3", o_lv, 1'b1);
    s_done = 1'b0; s_hit = 1'b0;
    step(); chk("t1_rsp_T4", o_rsp, 3'b001); chk("t1_hit_T4", o_hit, 1'b1);
    chk("t1_lv_T4", o_lv, 1'b0);
    step(); chk("t1_busy_T5", o_busy, 1'b0);
    chk("t1_accepts", acc_id_q.size(), 1);
`ifdef LLC_ARB_STATS_EN
    chk("t1_reads", stat_reads, 4'd1);
    chk("t1_hits", stat_hits, 4'd1);
`endif

    // Test 2: requesters 0 and 1 always valid, done in first WAIT cycle.
    do_reset();
    acc_cyc_q.delete(); acc_id_q.delete();
    s_valid = 3'b011; s_cmd[0] = 4'd1; s_addr[0] = 32'hA0; s_cmd[1] = 4'd2; s_addr[1] = 32'hB1;
    s_done = 1'b1;
    repeat (12) step();
    chk("t2_count", acc_id_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_id_q.size(); i++) begin
      chk("t2_order", acc_id_q[i], i % 2);
      if (i > 0) chk("t2_spacing", acc_cyc_q[i] - acc_cyc_q[i-1], 3);
    end

    // Test 3: all requesters valid gives 0,1,2,0.
    do_reset();
    acc_cyc_q.delete(); acc_id_q.delete();
    s_valid = 3'b111; s_cmd[2] = 4'd3; s_addr[2] = 32'hC2;
    s_done = 1'b1;
    repeat (12) step();
    chk("t3_count", acc_id_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_id_q.size(); i++) chk("t3_order", acc_id_q[i], i % 3);

    // Test 4: llc_done while idle is ignored.
    do_reset();
    s_valid = '0; s_done = 1'b1;
    repeat (3) begin
      step();
      chk("t4_idle_busy", o_busy, 1'b0);
      chk("t4_idle_rsp", o_rsp, 3'b000);
    end
    s_done = 1'b0;

    // Test 5: reset asserted during WAIT drops the operation.
    do_reset();
    acc_cyc_q.delete(); acc_id_q.delete();
    s_valid = 3'b010; s_cmd[1] = 4'd1; s_addr[1] = 32'hDEAD_0001;
    step();
    s_valid = '0;
    step(); chk("t5_lv_before", o_lv, 1'b1);
    #2; rst_n = 1'b0; llc_done = 1'b1; s_done = 1'b1;
    #1;
    chk("t5_lv_async", llc_valid, 1'b0);
    chk("t5_busy_async", busy, 1'b0);
    chk("t5_cmd_async", llc_cmd, 4'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; llc_done = 1'b0; s_done = 1'b0;
    model_reset();
    acc_id_q.delete(); acc_cyc_q.delete();
    s_valid = 3'b011;
    step();
    chk("t5_first_winner", acc_id_q.size() > 0 ? acc_id_q[0] : -1, 0);
    s_valid = '0; s_done = 1'b1;
    repeat (3) step();
    s_done = 1'b0;

`ifdef LLC_ARB_STATS_EN
    // Test 6: commands 1,2,3,8 all missing.
    do_reset();
    run_op(4'd1, 1'b0, 1'b0);
    run_op(4'd2, 1'b0, 1'b0);
    run_op(4'd3, 1'b0, 1'b0);
    run_op(4'd8, 1'b0, 1'b0);
    chk("t6_writes", stat_writes, 4'd1);
    chk("t6_reads", stat_reads, 4'd1);
    chk("t6_misses", stat_misses, 4'd2);
    chk("t6_hits", stat_hits, 4'd0);

    // Test 7: saturation at 0xF and clear winning over increment.
    do_reset();
    repeat (15) run_op(4'd0, 1'b1, 1'b0);
    chk("t7_hits_15", stat_hits, 4'hF);
    run_op(4'd0, 1'b1, 1'b0);
    chk("t7_hits_sat", stat_hits, 4'hF);
    chk("t7_reads_sat", stat_reads, 4'hF);
    run_op(4'd0, 1'b1, 1'b1);
    chk("t7_hits_clr", stat_hits, 4'h0);
    chk("t7_reads_clr", stat_reads, 4'h0);
`endif

    // Randomized traffic with held pending requests.
    do_reset();
    t0 = acc_id_q.size();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!(s_valid[i] && i != last_win)) begin
          s_valid[i] = ($urandom_range(2, 0) == 0);
          s_cmd[i]   = CMD_W'(cmd_pool[$urandom_range(8, 0)]);
          s_addr[i]  = $urandom;
        end
      end
      s_done = ($urandom_range(2, 0) == 0);
      s_hit  = $urandom_range(1, 0) == 1;
      s_clr  = ($urandom_range(49, 0) == 0);
      step();
    end
    s_valid = '0; s_clr = 1'b0; s_done = 1'b1;
    repeat (4) step();
    chk("rand_progress", acc_id_q.size() - t0 > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/llc_req_arbiter.md
# llc_req_arbiter

Round-robin arbiter and sequencer that shares the single last-level-cache (LLC) command port among several trace requesters, such as the data-side and instruction-side trace streams. It holds one in-flight LLC operation at a time and returns a hit/miss response to the requester that owns it. When the statistics option is compiled in, it also keeps read/write/hit/miss counters. It sits between the trace-driving front ends and the LLC model.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (legal 2..8)
- CMD_W, 4, command width (matches CMDSIZE)
- ADDR_W, 32, address width (matches ADDR_BITS)
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester command valid
- req_cmd  in  NUM_REQ*CMD_W  packed commands; requester i at [i*CMD_W +: CMD_W]
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, same packing
- req_ready  out  NUM_REQ  one-hot accept; transfer when valid&ready
- llc_valid  out  1  LLC operation active
- llc_cmd  out  CMD_W  registered command to LLC
- llc_addr  out  ADDR_W  registered address to LLC
- llc_id  out  $clog2(NUM_REQ)  owner of current operation
- llc_done  in  1  LLC completion strobe
- llc_hit  in  1  hit flag; valid only with llc_done
- rsp_valid  out  NUM_REQ  one-cycle response pulse to owner
- rsp_hit  out  1  registered llc_hit; valid with rsp_valid
- busy  out  1  high whenever state != IDLE
- stat_clr, stat_reads, stat_writes, stat_hits, stat_misses: these ports exist only with LLC_ARB_STATS_EN. stat_clr is in 1; the others are out CNT_W.

## Operation
- FSM states and transitions:
  - IDLE -> WAIT on grant.
  - WAIT -> RESP when llc_done is sampled high.
  - RESP -> IDLE unconditionally.
- Arbitration in IDLE only:
  - The search starts at last_grant+1 mod NUM_REQ and takes the first requester with valid set.
  - req_ready is combinational and one-hot for the winner. It is zero outside IDLE and when no requester is valid.
- On grant:
  - Capture cmd/addr/id into llc_cmd/llc_addr/llc_id.
  - Set last_grant to the winner.
- WAIT:
  - llc_valid is held high.
  - llc_cmd/llc_addr/llc_id are stable.
  - On llc_done, llc_hit is registered into rsp_hit.
- RESP: rsp_valid[llc_id]=1 and llc_valid=0.
- llc_done outside WAIT is ignored.
- Command classes:
  - Read = 0 or 2.
  - Write = 1.
  - All other commands (snoops 3-6, clear 8, print 9) are sequenced identically but are not statistics-counted.
- Mid-operation reset: the operation is dropped, the FSM returns to IDLE, and all outputs return to their reset values.

## Timing
- Reset values:
  - All outputs are 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - State = IDLE.
  - Counters are 0.
- Accept at cycle T.
- llc_valid rises at T+1.
- With llc_done first sampled at cycle D (D >= T+1):
  - llc_valid falls at D+1.
  - rsp_valid pulses at D+1.
  - IDLE is reached at D+2, and the next grant can be accepted at D+2.
- Minimum accept-to-accept spacing is 3 cycles.
- A requester holding valid across a non-granted cycle keeps its cmd/addr stable. The arbiter never drops a pending request.
- All requesters continuously valid gives a grant order of 0,1,...,NUM_REQ-1,0.

## Configuration
- LLC_ARB_STATS_EN defined:
  - Counters increment in the RESP cycle.
  - Reads count cmd 0/2 and writes count cmd 1.
  - Hits/misses count cmd 0/1/2 according to rsp_hit.
  - Counters saturate at all-ones.
  - stat_clr synchronously zeroes all counters and wins over a simultaneous increment.
- LLC_ARB_STATS_EN undefined: no counters, no stat_* ports, and arbitration is identical.

## Structure
- Shared package llc_pkg holds:
  - CMD_READ_D=0, CMD_WRITE_D=1, CMD_READ_I=2, and the snoop/clear/print constants.
  - The state typedef enum {IDLE, WAIT, RESP}.
  - An is_read/is_write/is_counted function set.
- One sub-module, llc_rr_pick: a combinational round-robin picker with inputs req vector and last_grant, and outputs one-hot grant, grant index and any.

## Test plan
- Single requester 0, cmd 0 addr 0x0000_1000, llc_done at T+3 with hit=1:
  - llc_valid is high T+1..T+3.
  - rsp_valid[0] pulses at T+4 with rsp_hit=1.
  - With stats: reads=1, hits=1.
- Requesters 0 and 1 continuously valid, done 1 cycle after each issue: grant order is 0,1,0,1 with accept spacing of exactly 3 cycles.
- llc_done pulsed while IDLE and in RESP: no state change and no rsp_valid.
- Command sequence 1, 2, 3, 8, each miss: writes=1, reads=1, misses=2, hits=0.
- Counters preset near saturation with CNT_W=4:
  - A 16th hit holds hits at 0xF.
  - stat_clr asserted in the RESP cycle gives 0, not 1.
- rst_n asserted low during WAIT:
  - llc_valid drops immediately (asynchronously).
  - After release, requester 0 wins first.
  - No rsp_valid pulse occurs for the dropped operation.
